// File: rtl/branch_pkg.sv
// Shared branch-resolution types and the taken predicate used by EX and the redirect sequencer.
package branch_pkg;

    typedef enum logic [1:0] {
        JZ  = 2'b00,
        JN  = 2'b01,
        JC  = 2'b10,
        JMP = 2'b11
    } jmp_type_t;

    localparam int C_IDX = 2;
    localparam int N_IDX = 1;
    localparam int Z_IDX = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        DRAIN    = 2'b10
    } seq_state_t;

    function automatic logic branch_taken(
        input logic       enable,
        input jmp_type_t  jtype,
        input logic [2:0] flags
    );
        logic cond;
        cond = 1'b0;
        case (jtype)
            JZ:      cond = flags[Z_IDX];
            JN:      cond = flags[N_IDX];
            JC:      cond = flags[C_IDX];
            default: cond = 1'b1;
        endcase
        return enable & cond;
    endfunction

endpackage

// File: rtl/branch_redirect_sequencer.sv
// PC redirect and IF/ID, ID/EX squash sequencer for taken branches resolved in EX.
// Optional macro BRANCH_STATS_EN adds a saturating taken-branch counter; otherwise taken_count reads 0.
//
// state    | meaning
// IDLE     | watching EX for a taken branch
// REDIRECT | pc_load asserted with the latched target, both stages flushed
// DRAIN    | flushes held for FLUSH_CYCLES unstalled cycles, EX ignored
module branch_redirect_sequencer
    import branch_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [2:0]        jump_selector,
    input  logic [2:0]        condition_signals,
    input  logic [ADDR_W-1:0] target_pc,
    input  logic              stall,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              busy,
    output logic [CNT_W-1:0]  taken_count
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    seq_state_t        state;
    logic [3:0]        drain_cnt;
    logic [ADDR_W-1:0] target_q;
    logic              taken;
    logic              accept;

    assign taken  = ex_valid & branch_taken(jump_selector[2],
                                            jmp_type_t'(jump_selector[1:0]),
                                            condition_signals);
    assign accept = (state == IDLE) & taken & ~stall;

    assign pc_target = target_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            target_q    <= '0;
            drain_cnt   <= '0;
            pc_load     <= 1'b0;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= REDIRECT;
                        target_q    <= target_pc;
                        pc_load     <= 1'b1;
                        flush_if_id <= 1'b1;
                        flush_id_ex <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                REDIRECT: begin
                    // Under stall the PC cannot take the load, so everything holds.
                    if (!stall) begin
                        state     <= DRAIN;
                        drain_cnt <= FLUSH_LOAD;
                        pc_load   <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (drain_cnt == 4'd1) begin
                            state       <= IDLE;
                            drain_cnt   <= '0;
                            flush_if_id <= 1'b0;
                            flush_id_ex <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    drain_cnt   <= '0;
                    pc_load     <= 1'b0;
                    flush_if_id <= 1'b0;
                    flush_id_ex <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_count <= '0;
        end else if (accept && (taken_count != {CNT_W{1'b1}})) begin
            taken_count <= taken_count + 1'b1;
        end
    end
`else
    assign taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a redirect-window model.
module tb_branch_redirect_sequencer;

    localparam int ADDR_W = 32;
    localparam int FC     = 2;
    localparam int CW     = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic [2:0]        jump_selector;
    logic [2:0]        condition_signals;
    logic [ADDR_W-1:0] target_pc;
    logic              stall;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              busy;
    logic [CW-1:0]     taken_count;

    int checks = 0;
    int errors = 0;

    // Model: remaining unstalled cycles of the redirect+drain window.
    int          win = 0;
    logic [31:0] m_tgt = '0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    branch_redirect_sequencer #(
        .ADDR_W(ADDR_W), .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .jump_selector(jump_selector),
        .condition_signals(condition_signals), .target_pc(target_pc), .stall(stall),
        .pc_load(pc_load), .pc_target(pc_target), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .busy(busy), .taken_count(taken_count)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic ev, input logic [2:0] sel, input logic [2:0] fl);
        if (!ev || !sel[2]) return 1'b0;
        case (sel[1:0])
            2'd0:    return fl[0];
            2'd1:    return fl[1];
            2'd2:    return fl[2];
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_update();
        if (rst) begin
            win = 0; m_tgt = '0; m_cnt = 0;
        end else if (win == 0) begin
            if (ref_taken(ex_valid, jump_selector, condition_signals) && !stall) begin
                win   = FC + 1;
                m_tgt = target_pc;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end else if (!stall) begin
            win--;
        end
    endtask

    task automatic check_outputs();
        check_val("pc_load",     64'(pc_load),     64'(win == FC + 1));
        check_val("flush_if_id", 64'(flush_if_id), 64'(win > 0));
        check_val("flush_id_ex", 64'(flush_id_ex), 64'(win > 0));
        check_val("busy",        64'(busy),        64'(win > 0));
        check_val("pc_target",   64'(pc_target),   64'(m_tgt));
`ifdef BRANCH_STATS_EN
        check_val("taken_count", 64'(taken_count), 64'(m_cnt));
`else
        check_val("taken_count", 64'(taken_count), 64'd0);
`endif
    endtask

    task automatic cycle(input logic r, input logic ev, input logic [2:0] sel,
                         input logic [2:0] fl, input logic [31:0] tg, input logic st);
        rst = r; ex_valid = ev; jump_selector = sel; condition_signals = fl;
        target_pc = tg; stall = st;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 3'b000, 3'b000, 32'h0, 0);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 0; jump_selector = 0; condition_signals = 0;
        target_pc = 0; stall = 0;
        @(negedge clk);
        cycle(1, 0, 3'b000, 3'b000, 32'h0, 0);
        cycle(1, 0, 3'b000, 3'b000, 32'h0, 0);

        // JZ with Z set: one-shot load of 0x40, flushes over redirect plus two drain cycles
        idle_cycles(2);
        cycle(0, 1, 3'b100, 3'b001, 32'h0000_0040, 0);
        check_val("jz_pc_load", 64'(pc_load), 64'd1);
        check_val("jz_target",  64'(pc_target), 64'h40);
        cycle(0, 0, 3'b000, 3'b000, 32'h0, 0);
        check_val("jz_pc_load_once", 64'(pc_load), 64'd0);
        idle_cycles(2);
        check_val("jz_busy_done", 64'(busy), 64'd0);

        // JN with only Z set: not taken; then with N set: taken
        cycle(0, 1, 3'b101, 3'b001, 32'h0000_1000, 0);
        check_val("jn_not_taken", 64'(busy), 64'd0);
        cycle(0, 1, 3'b101, 3'b010, 32'h0000_2000, 0);
        idle_cycles(4);

        // Disabled selector never redirects, even for JMP type and all flags
        cycle(0, 1, 3'b011, 3'b111, 32'h0000_3000, 0);
        check_val("en_off", 64'(pc_load), 64'd0);

        // JMP then three stalled REDIRECT cycles
        cycle(0, 1, 3'b111, 3'b000, 32'h0000_4000, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 3'b000, 3'b000, 32'h0, 1);
        check_val("stall_hold", 64'(pc_load), 64'd1);
        idle_cycles(3);

        // Taken JC held across DRAIN into first IDLE cycle: only the latter is accepted
        cycle(0, 1, 3'b110, 3'b100, 32'h0000_5000, 0);
        cycle(0, 1, 3'b110, 3'b100, 32'h0000_6000, 0);
        cycle(0, 1, 3'b110, 3'b100, 32'h0000_7000, 0);
        cycle(0, 1, 3'b110, 3'b100, 32'h0000_8000, 0);
        cycle(0, 1, 3'b110, 3'b100, 32'h0000_9000, 0);
        check_val("b2b_target", 64'(pc_target), 64'h9000);
        idle_cycles(1);

        // Reset mid-DRAIN
        cycle(1, 0, 3'b000, 3'b000, 32'h0, 0);
        cycle(0, 1, 3'b111, 3'b000, 32'h0000_A000, 0);
        cycle(0, 0, 3'b000, 3'b000, 32'h0, 0);
        cycle(1, 0, 3'b000, 3'b000, 32'h0, 0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_target", 64'(pc_target), 64'd0);

        // Five JMPs: counter saturates in the stats build
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 3'b111, 3'b000, 32'h100 * (i + 1), 0);
            idle_cycles(FC + 1);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                  3'($urandom), 3'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
